// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared types and encodings for the MIPS multicycle control FSM
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BR, CLS_JMP, CLS_ILL
    } op_class_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FUNC_JR    = 6'h08;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP = 2'd2;
    localparam logic [1:0] PC_SRC_JR   = 2'd3;

    localparam logic [1:0] REG_DST_RT   = 2'd0;
    localparam logic [1:0] REG_DST_RD   = 2'd1;
    localparam logic [1:0] REG_DST_LINK = 2'd2;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC  = 2'd2;

endpackage

// File: rtl/mips_op_decode.sv
// rtl/mips_op_decode.sv - combinational classification of the latched instruction register
module mips_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output op_class_t   op_class,
    output logic        is_jal,
    output logic        is_jr,
    output logic        is_halt
);

    logic [5:0] op;
    logic [5:0] func;

    assign op   = ir[31:26];
    assign func = ir[5:0];

    always_comb begin
        op_class = CLS_ILL;
        if (op == OP_SPECIAL)
            op_class = (func == FUNC_JR) ? CLS_JMP : CLS_R;
        else if (op == OP_J || op == OP_JAL)
            op_class = CLS_JMP;
        else if (op == OP_REGIMM || (op >= 6'h04 && op <= 6'h07))
            op_class = CLS_BR;
        else if (op >= 6'h08 && op <= 6'h0F)
            op_class = CLS_IALU;
        else if (op >= 6'h20 && op <= 6'h26)
            op_class = CLS_LOAD;
        else if (op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E})
            op_class = CLS_STORE;
    end

    assign is_jal  = (op == OP_JAL);
    assign is_jr   = (op == OP_SPECIAL) && (func == FUNC_JR);
    assign is_halt = (ir == HALT_WORD);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle control FSM sequencing the MIPS datapath with memory handshakes
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             branch_taken,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_src,
    output logic             alu_src_b,
    output logic             halted,
    output logic             err,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       ir;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  retired_q;
    logic              err_q;
    logic              retire;

    op_class_t op_class;
    logic      is_jal;
    logic      is_jr;
    logic      is_halt;

    mips_op_decode u_decode (
        .ir       (ir),
        .op_class (op_class),
        .is_jal   (is_jal),
        .is_jr    (is_jr),
        .is_halt  (is_halt)
    );

    logic mem_state;
    logic waiting;
    logic timeout;

    assign mem_state = (state == S_FETCH) || (state == S_MEM);
    assign waiting   = (state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready);
    assign timeout   = mem_state && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_FETCH;
            ir        <= '0;
            wait_cnt  <= '0;
            retired_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (waiting && !timeout) ? wait_cnt + 1'b1 : '0;
            if (ir_we)
                ir <= instr;
            if (timeout)
                err_q <= 1'b1;
            if (retire)
                retired_q <= retired_q + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH:  if (timeout) state_nxt = S_HALT;
                      else if (imem_ready) state_nxt = S_DECODE;
            S_DECODE: if (is_halt) state_nxt = S_HALT;
                      else if (op_class == CLS_JMP) state_nxt = S_JUMP;
                      else if (op_class == CLS_ILL) state_nxt = S_FETCH;
                      else state_nxt = S_EXEC;
            S_EXEC:   if (op_class == CLS_R || op_class == CLS_IALU) state_nxt = S_WB;
                      else if (op_class == CLS_LOAD || op_class == CLS_STORE) state_nxt = S_MEM;
                      else state_nxt = S_FETCH;
            S_MEM:    if (timeout) state_nxt = S_HALT;
                      else if (dmem_ready) state_nxt = (op_class == CLS_LOAD) ? S_WB : S_FETCH;
            S_WB:     state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Timeout cycles issue no strobes; the err/HALT transition happens on the next edge.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PC_SRC_SEQ;
        reg_we    = 1'b0;
        reg_dst   = REG_DST_RT;
        wb_src    = WB_SRC_ALU;
        alu_src_b = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        if (!reset) begin
            unique case (state)
                S_FETCH: begin
                    if (!timeout) begin
                        imem_req = 1'b1;
                        ir_we    = imem_ready;
                        pc_we    = imem_ready;
                    end
                end
                S_DECODE: begin
                    if (op_class == CLS_ILL && !is_halt) begin
                        illegal = 1'b1;
                        retire  = 1'b1;
                    end
                end
                S_EXEC, S_MEM, S_WB: begin
                    alu_src_b = (op_class == CLS_IALU) || (op_class == CLS_LOAD) || (op_class == CLS_STORE);
                    reg_dst   = (op_class == CLS_R) ? REG_DST_RD : REG_DST_RT;
                    wb_src    = (op_class == CLS_LOAD) ? WB_SRC_MEM : WB_SRC_ALU;
                    if (state == S_EXEC && op_class == CLS_BR) begin
                        pc_we  = branch_taken;
                        pc_src = PC_SRC_BR;
                        retire = 1'b1;
                    end
                    if (state == S_MEM && !timeout) begin
                        dmem_req = 1'b1;
                        dmem_we  = (op_class == CLS_STORE);
                        retire   = (op_class == CLS_STORE) && dmem_ready;
                    end
                    if (state == S_WB) begin
                        reg_we = 1'b1;
                        retire = 1'b1;
                    end
                end
                S_JUMP: begin
                    pc_we  = 1'b1;
                    pc_src = is_jr ? PC_SRC_JR : PC_SRC_JUMP;
                    retire = 1'b1;
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = REG_DST_LINK;
                        wb_src  = WB_SRC_PC;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted  = (state == S_HALT);
    assign err     = err_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
    logic [1:0]  pc_src, reg_dst, wb_src;
    logic        alu_src_b, halted, err, illegal;
    logic [31:0] retired;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mips_multicycle_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .instr        (instr),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .reg_we       (reg_we),
        .reg_dst      (reg_dst),
        .wb_src       (wb_src),
        .alu_src_b    (alu_src_b),
        .halted       (halted),
        .err          (err),
        .illegal      (illegal),
        .retired      (retired)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 1 (state FETCH); caller drives inputs then waits #1.
    task automatic do_reset();
        reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0; instr = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; instr = 32'h012A4020;
        tick(); tick();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_imem_req got %0d exp 0", imem_req); end
        n_chk++; if (ir_we !== 1'b0) begin n_fail++; $display("FAIL reset_ir_we got %0d exp 0", ir_we); end
        n_chk++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL reset_pc_we got %0d exp 0", pc_we); end
        n_chk++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_req got %0d exp 0", dmem_req); end
        n_chk++; if (retired !== 32'd0) begin n_fail++; $display("FAIL reset_retired got %0d exp 0", retired); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0d exp 0", err); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %0d exp 0", halted); end
        reset = 1'b0; #1;
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_imem_req got %0d exp 1", imem_req); end
        n_chk++; if (ir_we !== 1'b1) begin n_fail++; $display("FAIL post_reset_ir_we got %0d exp 1", ir_we); end
    endtask

    task automatic test_rtype();
        do_reset();
        instr = 32'h012A4020; imem_ready = 1'b1; dmem_ready = 1'b1; #1;
        n_chk++; if (pc_we !== 1'b1 || pc_src !== 2'd0) begin n_fail++; $display("FAIL rtype_c1_pc got we=%0d src=%0d exp we=1 src=0", pc_we, pc_src); end
        tick();
        n_chk++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rtype_c2_imem_req got %0d exp 0", imem_req); end
        tick();
        n_chk++; if (reg_we !== 1'b0 || alu_src_b !== 1'b0) begin n_fail++; $display("FAIL rtype_c3 got reg_we=%0d alu_src_b=%0d exp 0 0", reg_we, alu_src_b); end
        tick();
        n_chk++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL rtype_c4_reg_we got %0d exp 1", reg_we); end
        n_chk++; if (reg_dst !== 2'd1 || wb_src !== 2'd0) begin n_fail++; $display("FAIL rtype_c4_sel got reg_dst=%0d wb_src=%0d exp 1 0", reg_dst, wb_src); end
        tick();
        n_chk++; if (retired !== 32'd1) begin n_fail++; $display("FAIL rtype_retired got %0d exp 1", retired); end
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rtype_refetch got %0d exp 1", imem_req); end
    endtask

    task automatic test_load_wait();
        do_reset();
        instr = 32'h8D090004; imem_ready = 1'b1; dmem_ready = 1'b1; #1;
        tick(); imem_ready = 1'b0; #1;
        tick();
        n_chk++; if (dmem_req !== 1'b0) begin n_fail++; $display("FAIL load_c3_dmem_req got %0d exp 0", dmem_req); end
        n_chk++; if (alu_src_b !== 1'b1) begin n_fail++; $display("FAIL load_c3_alu_src_b got %0d exp 1", alu_src_b); end
        tick(); dmem_ready = 1'b0; #1;
        n_chk++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL load_c4 got req=%0d we=%0d exp 1 0", dmem_req, dmem_we); end
        tick(); tick();
        tick(); dmem_ready = 1'b1; #1;
        n_chk++; if (dmem_req !== 1'b1 || reg_we !== 1'b0) begin n_fail++; $display("FAIL load_c7 got req=%0d reg_we=%0d exp 1 0", dmem_req, reg_we); end
        tick();
        n_chk++; if (reg_we !== 1'b1 || wb_src !== 2'd1 || reg_dst !== 2'd0) begin n_fail++; $display("FAIL load_c8 got reg_we=%0d wb_src=%0d reg_dst=%0d exp 1 1 0", reg_we, wb_src, reg_dst); end
        n_chk++; if (retired !== 32'd0) begin n_fail++; $display("FAIL load_c8_retired got %0d exp 0", retired); end
        tick();
        n_chk++; if (retired !== 32'd1) begin n_fail++; $display("FAIL load_retired got %0d exp 1", retired); end
    endtask

    task automatic test_store_fast();
        do_reset();
        instr = 32'hAD090004; imem_ready = 1'b1; dmem_ready = 1'b1; #1;
        tick(); imem_ready = 1'b0; #1;
        tick(); tick();
        n_chk++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || reg_we !== 1'b0) begin n_fail++; $display("FAIL store_c4 got req=%0d we=%0d reg_we=%0d exp 1 1 0", dmem_req, dmem_we, reg_we); end
        tick();
        n_chk++; if (retired !== 32'd1 || imem_req !== 1'b1 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL store_done got retired=%0d imem_req=%0d dmem_we=%0d exp 1 1 0", retired, imem_req, dmem_we); end
    endtask

    task automatic test_branch();
        do_reset();
        instr = 32'h11090003; imem_ready = 1'b1; branch_taken = 1'b1; #1;
        tick(); imem_ready = 1'b0; #1;
        tick();
        n_chk++; if (pc_we !== 1'b1 || pc_src !== 2'd1) begin n_fail++; $display("FAIL beq_taken_c3 got we=%0d src=%0d exp 1 1", pc_we, pc_src); end
        n_chk++; if (reg_we !== 1'b0) begin n_fail++; $display("FAIL beq_taken_reg_we got %0d exp 0", reg_we); end
        tick();
        n_chk++; if (retired !== 32'd1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL beq_taken_done got retired=%0d imem_req=%0d exp 1 1", retired, imem_req); end
        do_reset();
        instr = 32'h11090003; imem_ready = 1'b1; branch_taken = 1'b0; #1;
        tick(); imem_ready = 1'b0; #1;
        tick();
        n_chk++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken_pc_we got %0d exp 0", pc_we); end
        tick();
        n_chk++; if (retired !== 32'd1) begin n_fail++; $display("FAIL beq_not_taken_retired got %0d exp 1", retired); end
    endtask

    task automatic test_back_to_back_jumps();
        do_reset();
        instr = 32'h0C000010; imem_ready = 1'b1; #1;
        tick();
        n_chk++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL jal_c2_pc_we got %0d exp 0", pc_we); end
        tick();
        n_chk++; if (pc_we !== 1'b1 || pc_src !== 2'd2) begin n_fail++; $display("FAIL jal_pc got we=%0d src=%0d exp 1 2", pc_we, pc_src); end
        n_chk++; if (reg_we !== 1'b1 || reg_dst !== 2'd2 || wb_src !== 2'd2) begin n_fail++; $display("FAIL jal_link got reg_we=%0d reg_dst=%0d wb_src=%0d exp 1 2 2", reg_we, reg_dst, wb_src); end
        tick(); instr = 32'h03E00008; #1;
        n_chk++; if (retired !== 32'd1 || ir_we !== 1'b1) begin n_fail++; $display("FAIL jr_fetch got retired=%0d ir_we=%0d exp 1 1", retired, ir_we); end
        tick(); tick();
        n_chk++; if (pc_we !== 1'b1 || pc_src !== 2'd3 || reg_we !== 1'b0) begin n_fail++; $display("FAIL jr_c3 got we=%0d src=%0d reg_we=%0d exp 1 3 0", pc_we, pc_src, reg_we); end
        tick();
        n_chk++; if (retired !== 32'd2) begin n_fail++; $display("FAIL jr_retired got %0d exp 2", retired); end
    endtask

    task automatic test_illegal_halt();
        do_reset();
        instr = 32'hFC000000; imem_ready = 1'b1; #1;
        tick();
        n_chk++; if (illegal !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL illegal_c2 got illegal=%0d halted=%0d exp 1 0", illegal, halted); end
        tick(); instr = 32'hFFFF_FFFF; #1;
        n_chk++; if (illegal !== 1'b0 || retired !== 32'd1 || imem_req !== 1'b1) begin n_fail++; $display("FAIL illegal_done got illegal=%0d retired=%0d imem_req=%0d exp 0 1 1", illegal, retired, imem_req); end
        tick();
        n_chk++; if (halted !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL halt_c2 got halted=%0d illegal=%0d exp 0 0", halted, illegal); end
        tick();
        n_chk++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_c3 got halted=%0d imem_req=%0d exp 1 0", halted, imem_req); end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_chk++; if (halted !== 1'b1 || imem_req !== 1'b0 || ir_we !== 1'b0) begin n_fail++; $display("FAIL halt_hold_%0d got halted=%0d imem_req=%0d ir_we=%0d exp 1 0 0", i, halted, imem_req, ir_we); end
        end
        n_chk++; if (retired !== 32'd1) begin n_fail++; $display("FAIL halt_retired got %0d exp 1", retired); end
        reset = 1'b1; tick();
        n_chk++; if (halted !== 1'b0 || retired !== 32'd0) begin n_fail++; $display("FAIL halt_reset got halted=%0d retired=%0d exp 0 0", halted, retired); end
        reset = 1'b0; #1;
        n_chk++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL halt_refetch got %0d exp 1", imem_req); end
    endtask

    task automatic test_timeout();
        do_reset();
        instr = 32'hAD090004; imem_ready = 1'b1; dmem_ready = 1'b0; #1;
        tick(); imem_ready = 1'b0; #1;
        tick(); tick();
        n_chk++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || alu_src_b !== 1'b1) begin n_fail++; $display("FAIL tmo_c4 got req=%0d we=%0d alu_src_b=%0d exp 1 1 1", dmem_req, dmem_we, alu_src_b); end
        repeat (15) tick();
        n_chk++; if (dmem_req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL tmo_last_wait got req=%0d err=%0d exp 1 0", dmem_req, err); end
        tick();
        n_chk++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL tmo_expire got req=%0d we=%0d halted=%0d exp 0 0 0", dmem_req, dmem_we, halted); end
        tick();
        n_chk++; if (err !== 1'b1 || halted !== 1'b1) begin n_fail++; $display("FAIL tmo_halt got err=%0d halted=%0d exp 1 1", err, halted); end
        dmem_ready = 1'b1; repeat (3) tick();
        n_chk++; if (err !== 1'b1 || dmem_req !== 1'b0 || retired !== 32'd0) begin n_fail++; $display("FAIL tmo_sticky got err=%0d req=%0d retired=%0d exp 1 0 0", err, dmem_req, retired); end
        reset = 1'b1; tick();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_reset_err got %0d exp 0", err); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        instr = 32'hAD090004; imem_ready = 1'b1; dmem_ready = 1'b0; #1;
        tick(); imem_ready = 1'b0; #1;
        tick(); tick();
        n_chk++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL midmem_c4_we got %0d exp 1", dmem_we); end
        tick(); reset = 1'b1; #1;
        n_chk++; if (dmem_we !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL midmem_in_reset got we=%0d req=%0d exp 0 0", dmem_we, dmem_req); end
        tick();
        reset = 1'b0; dmem_ready = 1'b1; #1;
        n_chk++; if (imem_req !== 1'b1 || dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL midmem_after got imem_req=%0d dmem_req=%0d dmem_we=%0d exp 1 0 0", imem_req, dmem_req, dmem_we); end
        tick();
        n_chk++; if (dmem_we !== 1'b0 || retired !== 32'd0) begin n_fail++; $display("FAIL midmem_no_store got we=%0d retired=%0d exp 0 0", dmem_we, retired); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_store_fast();
        test_branch();
        test_back_to_back_jumps();
        test_illegal_halt();
        test_timeout();
        test_reset_mid_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
